// File: rtl/countdown_arbiter.sv
// Round-robin arbiter sharing one down counter among N_REQ requesters.
// The owner's start value is loaded, counted to zero, and a done pulse is returned.
module countdown_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   load_val,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic [CNT_W-1:0]         count,
    output logic [N_REQ-1:0]         done
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COUNT  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state_reg,  state_next;
    logic [N_REQ-1:0]    grant_reg,  grant_next;
    logic                busy_reg,   busy_next;
    logic [CNT_W-1:0]    count_reg,  count_next;
    logic [N_REQ-1:0]    done_reg,   done_next;
    logic [PW-1:0]       ptr_reg,    ptr_next;
    logic [PW-1:0]       winner_reg, winner_next;

    logic [CNT_W-1:0]    load_slice [N_REQ];
    logic                rr_found;
    logic [PW-1:0]       rr_winner;
    logic [PW-1:0]       rr_idx_w;
    logic [N_REQ-1:0]    rr_onehot;
    int                  rr_idx;
    logic [PW-1:0]       ptr_after;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign load_slice[gi] = load_val[gi*CNT_W +: CNT_W];
        end
    endgenerate

    // Search starts at ptr and wraps, so the first set bit at or after ptr wins.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        rr_idx    = 0;
        rr_idx_w  = '0;
        rr_onehot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_idx = int'(ptr_reg) + k;
            if (rr_idx >= N_REQ) begin
                rr_idx = rr_idx - N_REQ;
            end
            rr_idx_w = PW'(rr_idx);
            if (!rr_found && req[rr_idx_w]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx_w;
            end
        end
        rr_onehot[rr_winner] = 1'b1;
    end

    assign ptr_after = (winner_reg == PW'(N_REQ - 1)) ? '0 : winner_reg + PW'(1);

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        busy_next   = busy_reg;
        count_next  = count_reg;
        done_next   = done_reg;
        ptr_next    = ptr_reg;
        winner_next = winner_reg;
        case (state_reg)
            IDLE: begin
                if (rr_found) begin
                    winner_next = rr_winner;
                    grant_next  = rr_onehot;
                    busy_next   = 1'b1;
                    state_next  = LOAD;
                end
            end
            LOAD, COUNT: begin
                // A dropped request outranks both loading and completion.
                if (!req[winner_reg]) begin
                    state_next = IDLE;
                    grant_next = '0;
                    busy_next  = 1'b0;
                    count_next = '0;
                    ptr_next   = ptr_after;
                end else if (state_reg == LOAD) begin
                    count_next = load_slice[winner_reg];
                    state_next = COUNT;
                end else if (count_reg != '0) begin
                    count_next = count_reg - CNT_W'(1);
                end else begin
                    done_next[winner_reg] = 1'b1;
                    state_next            = FINISH;
                end
            end
            FINISH: begin
                done_next  = '0;
                grant_next = '0;
                busy_next  = 1'b0;
                ptr_next   = ptr_after;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            busy_reg   <= 1'b0;
            count_reg  <= '0;
            done_reg   <= '0;
            ptr_reg    <= '0;
            winner_reg <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            busy_reg   <= busy_next;
            count_reg  <= count_next;
            done_reg   <= done_next;
            ptr_reg    <= ptr_next;
            winner_reg <= winner_next;
        end
    end

    assign grant = grant_reg;
    assign busy  = busy_reg;
    assign count = count_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_countdown_arbiter.sv
// Directed and random stimulus for countdown_arbiter, checked every cycle against
// a timeline model: each grant is an interval measured in edges since the grant.
module tb_countdown_arbiter;

    localparam int N_REQ = 4;
    localparam int CNT_W = 7;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*CNT_W-1:0]  load_val;
    logic [N_REQ-1:0]        grant;
    logic                    busy;
    logic [CNT_W-1:0]        count;
    logic [N_REQ-1:0]        done;

    countdown_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .load_val (load_val),
        .grant    (grant),
        .busy     (busy),
        .count    (count),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: owner index (-1 = none), edges since grant, captured start value, pointer.
    int m_owner, m_k, m_v, m_ptr;
    logic [N_REQ-1:0] exp_grant, exp_done;
    logic             exp_busy;
    logic [CNT_W-1:0] exp_count;

    task automatic model_outputs();
        int c;
        if (m_owner < 0) begin
            exp_grant = '0; exp_busy = 1'b0; exp_count = '0; exp_done = '0;
        end else begin
            exp_grant = '0;
            exp_grant[m_owner] = 1'b1;
            exp_busy = 1'b1;
            c = (m_k == 0) ? 0 : m_v - (m_k - 1);
            if (c < 0) c = 0;
            exp_count = CNT_W'(c);
            exp_done = (m_k == m_v + 2) ? exp_grant : '0;
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_k = 0; m_v = 0; m_ptr = 0;
        model_outputs();
    endtask

    task automatic model_release();
        m_ptr = (m_owner + 1) % N_REQ;
        m_owner = -1;
    endtask

    task automatic model_edge();
        if (m_owner < 0) begin
            if (req != '0) begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % N_REQ]) m_owner = (m_ptr + k) % N_REQ;
                end
                m_k = 0;
            end
        end else begin
            m_k++;
            if (m_k == 1) begin
                if (!req[m_owner]) model_release();
                else m_v = int'(load_val[m_owner*CNT_W +: CNT_W]);
            end else if (m_k <= m_v + 2) begin
                if (!req[m_owner]) model_release();
            end else begin
                model_release();
            end
        end
        model_outputs();
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (grant === exp_grant) else begin
            miscompares++;
            $error("FAIL %s grant: observed %b expected %b", tag, grant, exp_grant);
        end
        vectors++;
        assert (busy === exp_busy) else begin
            miscompares++;
            $error("FAIL %s busy: observed %b expected %b", tag, busy, exp_busy);
        end
        vectors++;
        assert (count === exp_count) else begin
            miscompares++;
            $error("FAIL %s count: observed %0d expected %0d", tag, count, exp_count);
        end
        vectors++;
        assert (done === exp_done) else begin
            miscompares++;
            $error("FAIL %s done: observed %b expected %b", tag, done, exp_done);
        end
    endtask

    // One clock: model follows the edge, DUT is sampled on the falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check(tag);
    endtask

    task automatic drain();
        req = '0;
        repeat (3) step("drain");
    endtask

    task automatic set_lv(input int i, input int v);
        load_val[i*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    logic [N_REQ-1:0] rr_seen [$];
    int               rr_time [$];
    logic [N_REQ-1:0] prev_grant;
    logic [N_REQ-1:0] rr_exp;

    initial begin
        rst_n = 1'b1; req = '0; load_val = '0;
        model_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset");
        rst_n = 1'b1;

        // Round-robin with all requesters active and start value 2
        req = 4'b1111;
        for (int i = 0; i < N_REQ; i++) set_lv(i, 2);
        prev_grant = '0;
        for (int t = 0; t < 28; t++) begin
            step("rr");
            if (grant != '0 && prev_grant == '0) begin
                rr_seen.push_back(grant);
                rr_time.push_back(t);
            end
            prev_grant = grant;
        end
        vectors++;
        assert (rr_seen.size() === 5) else begin
            miscompares++;
            $error("FAIL rr_grants: observed %0d expected %0d", rr_seen.size(), 5);
        end
        for (int i = 0; i < rr_seen.size() && i < 5; i++) begin
            rr_exp = '0;
            rr_exp[i % N_REQ] = 1'b1;
            vectors++;
            assert (rr_seen[i] === rr_exp) else begin
                miscompares++;
                $error("FAIL rr_order%0d: observed %b expected %b", i, rr_seen[i], rr_exp);
            end
            if (i > 0) begin
                vectors++;
                assert (rr_time[i] - rr_time[i-1] === 6) else begin
                    miscompares++;
                    $error("FAIL rr_gap%0d: observed %0d expected %0d", i, rr_time[i] - rr_time[i-1], 6);
                end
            end
        end
        drain();

        // Single requester, start value 5
        req = 4'b0001; set_lv(0, 5);
        repeat (8) step("single");
        drain();

        // Zero start value, then maximum start value
        req = 4'b0001; set_lv(0, 0);
        repeat (4) step("zero");
        drain();
        req = 4'b0001; set_lv(0, 127);
        repeat (131) step("max");
        drain();

        // Abandon by owner 2 at count 6 with requests 1 and 3 pending
        req = 4'b0100; set_lv(2, 10);
        for (int t = 0; t < 20 && count != 6; t++) step("abandon_run");
        vectors++;
        assert (count === 7'd6) else begin
            miscompares++;
            $error("FAIL abandon_reach: observed %0d expected %0d", count, 6);
        end
        req = 4'b1010;
        step("abandon_drop");
        step("abandon_next");
        vectors++;
        assert (grant === 4'b1000) else begin
            miscompares++;
            $error("FAIL abandon_ptr: observed %b expected %b", grant, 4'b1000);
        end
        drain();

        // Late change of load_val after it was sampled
        req = 4'b0010; set_lv(1, 4);
        step("late_grant");
        step("late_load");
        set_lv(1, 9);
        repeat (6) step("late_count");
        drain();

        // Reset mid-count, pointer must return to 0
        req = 4'b0001; set_lv(0, 50);
        for (int t = 0; t < 60 && count != 37; t++) step("rst_run");
        vectors++;
        assert (count === 7'd37) else begin
            miscompares++;
            $error("FAIL rst_reach: observed %0d expected %0d", count, 37);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111;
        step("rst_regrant");
        vectors++;
        assert (grant === 4'b0001) else begin
            miscompares++;
            $error("FAIL rst_ptr: observed %b expected %b", grant, 4'b0001);
        end
        drain();

        // Random requests and start values
        for (int t = 0; t < 800; t++) begin
            if ($urandom_range(0, 7) == 0) req = N_REQ'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                set_lv(int'($urandom_range(0, N_REQ - 1)),
                       ($urandom_range(0, 15) == 0) ? 127 : int'($urandom_range(0, 12)));
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/countdown_arbiter.md
# countdown_arbiter

Shares a single CNT_W-bit down-counter datapath among N_REQ requesters. Round-robin arbitration grants one requester at a time. The block loads that requester's start value, counts down to zero, then pulses a per-requester done flag. It sits in the COUNTER/DOWN_Counter family as the sequencing and sharing layer above the plain down counter, so several consumers can time intervals without each owning a counter.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- CNT_W, default 7: counter width in bits.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  level request per requester; must be held until done or abandon.
- load_val  input  N_REQ*CNT_W  start value per requester; slice i is bits [i*CNT_W +: CNT_W].
- grant  output  N_REQ  one-hot owner of the counter; all zeros when idle.
- busy  output  1  high while any requester owns the counter.
- count  output  CNT_W  current counter value.
- done  output  N_REQ  one-cycle completion pulse to the owner.

## Operation
- The FSM has four states: IDLE, LOAD, COUNT, FINISH.
- Reset (rst_n low, asynchronous): state=IDLE, grant=0, busy=0, count=0, done=0, round-robin pointer ptr=0.
- IDLE, with req nonzero:
  - Winner = first set bit of req, searching ptr, ptr+1, … mod N_REQ.
  - grant <= onehot(winner), busy <= 1, state <= LOAD.
- IDLE, with req zero: outputs hold; count=0.
- LOAD:
  - count <= load_val slice of winner, state <= COUNT.
  - load_val is sampled only here; later changes are ignored.
- COUNT:
  - If count != 0: count <= count-1.
  - If count == 0: done[winner] <= 1, state <= FINISH.
- FINISH:
  - done <= 0, grant <= 0, busy <= 0.
  - ptr <= (winner+1) mod N_REQ, state <= IDLE.
- Abandon: if req[winner] is low on any edge in LOAD or COUNT:
  - state <= IDLE, grant <= 0, busy <= 0, count <= 0.
  - No done pulse; ptr <= (winner+1) mod N_REQ.
- The abandon check takes priority over the count==0 check in the same cycle.
- Arithmetic: count is unsigned CNT_W bits and never decrements below 0, so it does not wrap.
- load_val = 0 is legal: COUNT sees zero on its first cycle and finishes immediately.
- Requests from non-owners during LOAD, COUNT or FINISH are ignored; they are arbitrated at the next IDLE.
- done is never asserted for more than one cycle or for a non-owner; grant is at most one-hot.

## Timing
- Let E0 be the edge in IDLE that issues the grant:
  - grant and busy are visible after E0.
  - count = V after E0+1.
  - count = 0 after E0+1+V.
  - done is high after E0+V+2 for exactly one cycle.
  - grant and busy drop after E0+V+3, in the same cycle done drops.
- Grant-to-done latency is V+2 cycles. Total occupancy from E0 to release is V+3 edges.
- The minimum gap is one IDLE cycle: the earliest next grant is at E0+V+4.
- The requester must hold req through the done cycle. Dropping req in the FINISH cycle has no effect.
- Abandon latency: one edge from the first cycle req[winner] is seen low in LOAD or COUNT.

## Test plan
- Reset mid-count: assert rst_n low with count=37 → immediately grant=0, busy=0, count=0, done=0. After release, the first grant goes to the lowest requesting index (ptr=0).
- Single requester: N_REQ=4, CNT_W=7, req=0001, load_val[0]=5 → grant=0001 after E0, count 5,4,3,2,1,0, done=0001 at E0+7 for one cycle, grant=0 at E0+8.
- Round-robin fairness: req=1111 held, all load_val=2 → grant order 0001, 0010, 0100, 1000, 0001; each done occurs 4 cycles after its grant, with one IDLE cycle between grants.
- Zero and maximum load: load_val=0 → done at E0+2. load_val=127 → done at E0+129, with count never wrapping below 0.
- Abandon: owner 2 with load_val=10 drops req when count=6 → next edge grant=0, count=0, no done. With req=1010 pending, the next grant is 1000, because ptr has advanced to 3.
- Late load_val change: load_val[1] changes from 4 to 9 one cycle after LOAD → done still occurs at E0+6.
